sweep_ctrl: RTL and testbench
=============================

Name: sweep_ctrl

Overview:
- Controller that sequences the team's 4-input combinational logic function (inputs A, B, C, D; output Y) through all 16 input combinations.
- It drives each vector, waits a programmable settle time, samples Y, and assembles the 16-bit truth table.
- It compares the table against an expected pattern and reports pass/fail, error count and first failing index.
- Sits between the logic function under test and a simple start/done host handshake (board switches or a higher-level test sequencer).

Parameters:
- SETTLE_CYC, 2, clock cycles each vector is held before Y is sampled; legal range 1..15.
- EXPECTED, 16'hADA7, golden truth table. Bit n = Y for vector n = {A,B,C,D}, A is MSB.
- Default value matches the existing function: Y = (B xnor D) or ((A xnor C) and (not B or D)).

Ports:
- iCLK  input  1  system clock, all state updates on rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iSTART  input  1  level-sampled start request; accepted only in IDLE or DONE.
- iABORT  input  1  synchronous abort; returns the block to IDLE from any state.
- iY  input  1  output of the logic function under test.
- oA  output  1  drive to function input A, registered.
- oB  output  1  drive to function input B, registered.
- oC  output  1  drive to function input C, registered.
- oD  output  1  drive to function input D, registered.
- oBUSY  output  1  high while a sweep is in progress.
- oDONE  output  1  high from sweep completion until the next accepted start, abort or reset.
- oTABLE  output  16  captured truth table.
- oPASS  output  1  valid when oDONE=1; 1 iff oTABLE == EXPECTED.
- oERR_CNT  output  5  number of mismatching bits, 0..16.
- oFAIL_IDX  output  4  lowest mismatching vector index; 0 when there is no mismatch.

Behaviour:
- Reset (iRST_N=0, asynchronous):
  - State = IDLE.
  - oA..oD = 0, oBUSY = 0, oDONE = 0, oTABLE = 0, oPASS = 0, oERR_CNT = 0, oFAIL_IDX = 0.
  - Internal idx = 0, cnt = 0.
- States:
  - IDLE: no sweep pending.
  - RUN: sweep in progress.
  - DONE: sweep complete, results held.
- IDLE or DONE with iSTART=1 at edge k:
  - Next state RUN; oBUSY = 1, oDONE = 0.
  - idx = 0, cnt = 0; oA..oD = 4'b0000.
  - oTABLE, oERR_CNT, oFAIL_IDX cleared to 0; oPASS = 0.
- RUN, each edge:
  - If cnt < SETTLE_CYC-1: cnt increments.
  - If cnt == SETTLE_CYC-1:
    - oTABLE[idx] = iY.
    - If iY != EXPECTED[idx]: oERR_CNT increments; if this is the first mismatch, oFAIL_IDX = idx.
    - cnt = 0.
    - If idx < 15: idx increments and oA..oD = idx+1 (A = MSB).
    - If idx == 15: go to DONE.
- Vector timing: each vector is driven for exactly SETTLE_CYC cycles; iY is sampled on the last edge of that window.
- Entering DONE, at edge k + 16*SETTLE_CYC:
  - oBUSY = 0, oDONE = 1.
  - oPASS = (final oERR_CNT == 0). Computed from the updated count, so a mismatch on vector 15 gives oPASS = 0.
  - oA..oD return to 0.
- DONE: all results held stable until an accepted start, an abort or a reset.
- iSTART in RUN: ignored. No restart and no queueing.
- iSTART held high continuously: a new sweep begins on the edge after DONE is entered. oDONE is high for exactly one cycle between sweeps.
- iABORT:
  - From RUN or DONE: next state IDLE; oBUSY = 0, oDONE = 0, oA..oD = 0.
  - oTABLE, oERR_CNT, oFAIL_IDX keep their partial values; oPASS = 0.
  - iABORT has priority over iSTART on the same edge.
- Reset during RUN: immediate return to reset values; no partial result survives.
- Width rules:
  - idx is 4-bit and never wraps inside a sweep; the DONE transition is taken instead.
  - cnt is 4-bit.
  - oERR_CNT is 5-bit so that 16 is representable.

Test Plan:
- Golden sweep, SETTLE_CYC=2, iY driven by the real function:
  - iSTART pulse at edge 0 -> oA..oD step 0..15 every 2 cycles.
  - oDONE=1 after edge 32; oTABLE=16'hADA7, oPASS=1, oERR_CNT=0, oFAIL_IDX=0.
- Stuck-at-0 Y (iY=0 constant) -> oTABLE=16'h0000, oERR_CNT=10, oFAIL_IDX=0, oPASS=0.
- Inverted Y, SETTLE_CYC=1 -> oDONE after 16 cycles; oTABLE=16'h5258, oERR_CNT=16, oFAIL_IDX=0, oPASS=0.
- Single fault, iY forced to 0 only when vector=15 -> oTABLE=16'h2DA7, oERR_CNT=1, oFAIL_IDX=15, oPASS=0.
- Abort and restart:
  - iABORT at edge 9 -> oBUSY=0, oDONE=0, oA..oD=0.
  - iSTART and iABORT both high on the same later edge -> stays IDLE.
  - iSTART alone -> full golden sweep passes.
- Reset mid-sweep: iRST_N=0 asynchronously mid-cycle while oBUSY=1 -> all outputs 0 immediately, with no clock edge needed; iSTART held high through the run -> oDONE one-cycle pulses, back-to-back sweeps.

Source files
------------

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives all 16 {A,B,C,D} input vectors into a 4-input logic
// function and holds each vector for SETTLE_CYC cycles. On the last cycle of
// each vector it samples Y and builds the 16-bit truth table. At the end of
// the sweep it compares the table with EXPECTED.
//
// Ports:
//   iCLK, iRST_N        clock, asynchronous active-low reset
//   iSTART              level start request, accepted in IDLE/DONE
//   iABORT              synchronous abort to IDLE, wins over iSTART
//   iY                  output of the function under test
//   oA..oD              registered vector drive, A is MSB
//   oBUSY / oDONE       sweep in progress / results valid
//   oTABLE              captured truth table, bit n = Y for vector n
//   oPASS               oTABLE == EXPECTED, meaningful while oDONE=1
//   oERR_CNT            number of mismatching bits (0..16)
//   oFAIL_IDX           lowest mismatching vector index, 0 if none
module sweep_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [15:0] EXPECTED   = 16'hADA7
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic        iABORT,
    input  logic        iY,
    output logic        oA,
    output logic        oB,
    output logic        oC,
    output logic        oD,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [15:0] oTABLE,
    output logic        oPASS,
    output logic [4:0]  oERR_CNT,
    output logic [3:0]  oFAIL_IDX
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 5;
    localparam int unsigned TBL_W = 16;

    // Last settle-counter value of a vector window; sampling happens here.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(15);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [IDX_W-1:0]   vec_q,      vec_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [TBL_W-1:0]   table_q,    table_d;
    logic               pass_q,     pass_d;
    logic [ERR_W-1:0]   err_cnt_q,  err_cnt_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;

    // State and result registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= '0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            table_q    <= table_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // Next-state and result update.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        busy_d     = busy_q;
        done_d     = done_q;
        table_d    = table_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_idx_d = fail_idx_q;

        if (iABORT) begin
            // Partial table and error info are kept for inspection.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            vec_d   = '0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (iSTART) begin
                        state_d    = ST_RUN;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                        idx_d      = '0;
                        cnt_d      = '0;
                        vec_d      = '0;
                        table_d    = '0;
                        err_cnt_d  = '0;
                        fail_idx_d = '0;
                        pass_d     = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d          = '0;
                        table_d[idx_q] = iY;
                        if (iY != EXPECTED[idx_q]) begin
                            // A zero count before this bit marks the first mismatch.
                            if (err_cnt_q == '0) begin
                                fail_idx_d = idx_q;
                            end
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (idx_q != IDX_LAST) begin
                            idx_d = idx_q + IDX_W'(1);
                            vec_d = idx_q + IDX_W'(1);
                        end else begin
                            // Pass uses the count including the final vector.
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            vec_d   = '0;
                            pass_d  = (err_cnt_d == '0);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    vec_d   = '0;
                end
            endcase
        end
    end

    assign oA        = vec_q[3];
    assign oB        = vec_q[2];
    assign oC        = vec_q[1];
    assign oD        = vec_q[0];
    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oTABLE    = table_q;
    assign oPASS     = pass_q;
    assign oERR_CNT  = err_cnt_q;
    assign oFAIL_IDX = fail_idx_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Testbench for sweep_ctrl: two instances (settle 2 and settle 1) sweep a
// modelled logic function; results are compared against a table-level model.
module tb_sweep_ctrl;

    localparam logic [15:0] GOLD = 16'hADA7;

    localparam int M_GOLD  = 0;
    localparam int M_ZERO  = 1;
    localparam int M_INV   = 2;
    localparam int M_F15   = 3;
    localparam int M_RAND  = 4;

    typedef struct {
        int          sel;      // 2 -> SETTLE_CYC=2 instance, 1 -> SETTLE_CYC=1
        int          mode;
        logic [15:0] pat;
        logic [15:0] tbl;
        logic [4:0]  err;
        logic [3:0]  fidx;
        logic        pass;
    } vec_t;

    typedef struct {
        logic        busy;
        logic        done;
        logic [15:0] tbl;
        logic [4:0]  err;
        logic [3:0]  fidx;
        logic        pass;
        logic [3:0]  vec;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start2, abort2, y2, a2, b2, c2, d2, busy2, done2, pass2;
    logic [15:0] tbl2;
    logic [4:0]  err2;
    logic [3:0]  fidx2;
    logic start1, abort1, y1, a1, b1, c1, d1, busy1, done1, pass1;
    logic [15:0] tbl1;
    logic [4:0]  err1;
    logic [3:0]  fidx1;

    int          mode2, mode1;
    logic [15:0] rnd_pat;
    int          n_checks = 0;
    int          n_fail   = 0;

    sweep_ctrl #(.SETTLE_CYC(2), .EXPECTED(GOLD)) dut2 (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start2), .iABORT(abort2), .iY(y2),
        .oA(a2), .oB(b2), .oC(c2), .oD(d2), .oBUSY(busy2), .oDONE(done2),
        .oTABLE(tbl2), .oPASS(pass2), .oERR_CNT(err2), .oFAIL_IDX(fidx2)
    );

    sweep_ctrl #(.SETTLE_CYC(1), .EXPECTED(GOLD)) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start1), .iABORT(abort1), .iY(y1),
        .oA(a1), .oB(b1), .oC(c1), .oD(d1), .oBUSY(busy1), .oDONE(done1),
        .oTABLE(tbl1), .oPASS(pass1), .oERR_CNT(err1), .oFAIL_IDX(fidx1)
    );

    // The function under test, written straight from its boolean definition.
    function automatic logic golden_y(input logic [3:0] v);
        logic a, b, c, d;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        return (b ~^ d) | ((a ~^ c) & (~b | d));
    endfunction

    function automatic logic model_y(input int m, input logic [3:0] v, input logic [15:0] pat);
        case (m)
            M_ZERO:  return 1'b0;
            M_INV:   return ~golden_y(v);
            M_F15:   return (v == 4'd15) ? 1'b0 : golden_y(v);
            M_RAND:  return pat[v];
            default: return golden_y(v);
        endcase
    endfunction

    always_comb y2 = model_y(mode2, {a2, b2, c2, d2}, rnd_pat);
    always_comb y1 = model_y(mode1, {a1, b1, c1, d1}, rnd_pat);

    // Result model: the table is whatever Y gives per vector; errors are the
    // popcount of the difference, fail index its lowest set bit.
    function automatic vec_t make_entry(input int sel, input int m, input logic [15:0] pat);
        vec_t        e;
        logic [15:0] diff;
        e.sel = sel; e.mode = m; e.pat = pat;
        for (int n = 0; n < 16; n++) e.tbl[n] = model_y(m, 4'(n), pat);
        diff   = e.tbl ^ GOLD;
        e.err  = '0;
        e.fidx = '0;
        for (int n = 15; n >= 0; n--) begin
            if (diff[n]) begin
                e.err  = e.err + 5'd1;
                e.fidx = 4'(n);
            end
        end
        e.pass = (diff == 16'h0000);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample(input int sel, output out_t o);
        if (sel == 1) begin
            o.busy = busy1; o.done = done1; o.tbl = tbl1; o.err = err1;
            o.fidx = fidx1; o.pass = pass1; o.vec = {a1, b1, c1, d1};
        end else begin
            o.busy = busy2; o.done = done2; o.tbl = tbl2; o.err = err2;
            o.fidx = fidx2; o.pass = pass2; o.vec = {a2, b2, c2, d2};
        end
    endtask

    task automatic drive_start(input int sel, input logic v);
        if (sel == 1) start1 = v; else start2 = v;
    endtask

    // One full sweep from a start pulse; checks latency, vector stepping and results.
    task automatic run_entry(input vec_t v);
        int   s;
        int   edges;
        int   bad;
        out_t o;
        s     = (v.sel == 1) ? 1 : 2;
        bad   = 0;
        rnd_pat = v.pat;
        if (v.sel == 1) mode1 = v.mode; else mode2 = v.mode;
        @(negedge clk);
        drive_start(v.sel, 1'b1);
        @(negedge clk);
        drive_start(v.sel, 1'b0);
        edges = 1;
        sample(v.sel, o);
        chk("busy_on", {o.busy, o.done}, 2'b10);
        while (!o.done && edges < 200) begin
            if (o.vec != 4'((edges - 1) / s)) bad++;
            @(negedge clk);
            edges++;
            sample(v.sel, o);
        end
        chk("latency", edges - 1, 16 * s);
        chk("vec_seq", bad, 0);
        chk("table", o.tbl, v.tbl);
        chk("err_cnt", o.err, v.err);
        chk("fail_idx", o.fidx, v.fidx);
        chk("pass", o.pass, v.pass);
        chk("done_idle", {o.busy, o.vec}, 5'b0);
    endtask

    task automatic chk_zero(input string name, input out_t o);
        chk(name, {o.busy, o.done, o.tbl, o.err, o.fidx, o.pass, o.vec}, '0);
    endtask

    vec_t vecs[8];
    out_t o;
    int   gap;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        mode2 = M_GOLD; mode1 = M_GOLD; rnd_pat = '0;

        vecs[0] = '{2, M_GOLD, 16'h0, 16'hADA7, 5'd0,  4'd0,  1'b1};
        vecs[1] = '{2, M_ZERO, 16'h0, 16'h0000, 5'd10, 4'd0,  1'b0};
        vecs[2] = '{1, M_INV,  16'h0, 16'h5258, 5'd16, 4'd0,  1'b0};
        vecs[3] = '{2, M_F15,  16'h0, 16'h2DA7, 5'd1,  4'd15, 1'b0};
        for (int i = 4; i < 8; i++)
            vecs[i] = make_entry((i % 2 == 0) ? 2 : 1, M_RAND, 16'($urandom));

        #12;
        sample(2, o);
        chk_zero("reset_state", o);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_entry(vecs[i]);

        // Abort at edge 9 of a golden sweep.
        mode2 = M_GOLD;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (8) @(negedge clk);
        abort2 = 1'b1;
        @(negedge clk); abort2 = 1'b0;
        sample(2, o);
        chk("abort_ctrl", {o.busy, o.done, o.vec, o.pass}, '0);
        chk("abort_partial", {o.tbl, o.err}, {16'h0007, 5'd0});

        // Start and abort together: abort wins, block stays idle.
        @(negedge clk); start2 = 1'b1; abort2 = 1'b1;
        @(negedge clk); start2 = 1'b0; abort2 = 1'b0;
        sample(2, o);
        chk("start_abort", {o.busy, o.done}, 2'b00);
        repeat (3) @(negedge clk);
        sample(2, o);
        chk("idle_hold", {o.busy, o.done, o.vec}, '0);
        run_entry(vecs[0]);

        // Asynchronous reset mid-sweep, then back-to-back sweeps with start held.
        mode2 = M_GOLD;
        @(negedge clk); start2 = 1'b1;
        repeat (6) @(negedge clk);
        sample(2, o);
        chk("busy_before_rst", o.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 sample(2, o);
        chk_zero("async_reset", o);
        @(negedge clk); rst_n = 1'b1;
        gap = 0;
        sample(2, o);
        while (!o.done && gap < 100) begin
            @(negedge clk); gap++; sample(2, o);
        end
        chk("first_done", o.done, 1'b1);
        chk("first_pass", {o.pass, o.tbl}, {1'b1, 16'hADA7});
        @(negedge clk); sample(2, o);
        chk("done_pulse", {o.done, o.busy}, 2'b01);
        gap = 1;
        while (!o.done && gap < 100) begin
            @(negedge clk); gap++; sample(2, o);
        end
        chk("restart_period", gap, 33);
        chk("second_pass", {o.pass, o.err}, {1'b1, 5'd0});
        start2 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
